// File: rtl/spi_mem_slave_if.sv
// Memory-side request/response bus between the SPI bridge and a TCM-style data port.
// The bridge owns the request side (master); the memory answers on the slave side.
interface spi_mem_slave_if;
    logic        mem_d_rd_o;
    logic [31:0] data_adr_o;
    logic [31:0] data_wr_o;
    logic [3:0]  data_wr_en_o;
    logic [31:0] data_rd_i;
    logic        mem_accept;
    logic        mem_ack;

    modport master (
        output mem_d_rd_o,
        output data_adr_o,
        output data_wr_o,
        output data_wr_en_o,
        input  data_rd_i,
        input  mem_accept,
        input  mem_ack
    );

    modport slave (
        input  mem_d_rd_o,
        input  data_adr_o,
        input  data_wr_o,
        input  data_wr_en_o,
        output data_rd_i,
        output mem_accept,
        output mem_ack
    );
endinterface

// File: rtl/spi_mem_slave.sv
// SPI slave bridging 72-bit LSB-first frames {cmd, addr, data} to single 32-bit memory accesses.
// The response to each frame is shifted out MSB-first on miso during the following frame.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | no frame in progress, no access pending
// SHIFT    | cs low, frame bits being collected
// MEM_REQ  | read or write request driven, waiting for mem_accept
// MEM_WAIT | request accepted, waiting for mem_ack
// DONE     | response word loaded into the TX register
module spi_mem_slave #(
    parameter int FRAME_W  = 72,
    parameter int SYNC_STG = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic sclk,
    input  logic cs,
    input  logic mosi,
    output logic miso,
    output logic start_flag,
    spi_mem_slave_if.master mem
);

    localparam int CNT_W = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0] FRAME_LEN = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(FRAME_W - 1);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SHIFT    = 3'd1;
    localparam logic [2:0] ST_MEM_REQ  = 3'd2;
    localparam logic [2:0] ST_MEM_WAIT = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

    logic [SYNC_STG-1:0] sclk_sync;
    logic [SYNC_STG-1:0] cs_sync;
    logic [SYNC_STG-1:0] mosi_sync;
    logic                sclk_d;
    logic                sclk_s;
    logic                mosi_s;
    logic                cs_act;
    logic                sclk_rise;
    logic                sclk_fall;

    logic [FRAME_W-1:0]  rx_sh;
    logic [CNT_W-1:0]    bitcnt;
    logic                frame_done;
    logic [FRAME_W-1:0]  frame_word;
    logic [7:0]          new_cmd;
    logic [31:0]         new_addr;
    logic [31:0]         new_data;

    logic [2:0]          state;
    logic [7:0]          cmd_q;
    logic [31:0]         addr_q;
    logic [31:0]         data_q;
    logic [FRAME_W-1:0]  resp;

    // cs resets to the deselected level so no phantom frame starts after reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STG-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STG-2:0], cs};
            mosi_sync <= {mosi_sync[SYNC_STG-2:0], mosi};
            sclk_d    <= sclk_sync[SYNC_STG-1];
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STG-1];
    assign mosi_s    = mosi_sync[SYNC_STG-1];
    assign cs_act    = ~cs_sync[SYNC_STG-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;

    assign frame_done = sclk_fall & cs_act & (bitcnt == LAST_BIT);
    assign frame_word = {mosi_s, rx_sh[FRAME_W-2:0]};
    assign new_cmd    = frame_word[FRAME_W-1 -: 8];
    assign new_addr   = frame_word[FRAME_W-9 -: 32];
    assign new_data   = frame_word[31:0];

    // bits past the end of the frame are dropped until cs re-arms the counter
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_sh  <= '0;
            bitcnt <= '0;
        end else if (!cs_act) begin
            bitcnt <= '0;
        end else if (sclk_fall && (bitcnt < FRAME_LEN)) begin
            rx_sh[bitcnt] <= mosi_s;
            bitcnt        <= bitcnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state            <= ST_IDLE;
            start_flag       <= 1'b0;
            cmd_q            <= '0;
            addr_q           <= '0;
            data_q           <= '0;
            resp             <= '0;
            mem.mem_d_rd_o   <= 1'b0;
            mem.data_adr_o   <= '0;
            mem.data_wr_o    <= '0;
            mem.data_wr_en_o <= '0;
        end else begin
            start_flag <= frame_done;

            if (sclk_rise && cs_act) begin
                resp <= {resp[FRAME_W-2:0], 1'b0};
            end

            case (state)
                ST_IDLE, ST_SHIFT: begin
                    if (frame_done) begin
                        cmd_q          <= new_cmd;
                        addr_q         <= new_addr;
                        data_q         <= new_data;
                        mem.data_adr_o <= new_addr;
                        mem.data_wr_o  <= new_data;
                        if (!new_cmd[7]) begin
                            mem.mem_d_rd_o <= 1'b1;
                            state          <= ST_MEM_REQ;
                        end else if (new_cmd[3:0] != 4'h0) begin
                            mem.data_wr_en_o <= new_cmd[3:0];
                            state            <= ST_MEM_REQ;
                        end else begin
                            // write with no byte lanes: skip the bus, still echo the frame
                            state <= ST_DONE;
                        end
                    end else if (cs_act) begin
                        state <= ST_SHIFT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end

                ST_MEM_REQ: begin
                    if (mem.mem_accept) begin
                        mem.mem_d_rd_o   <= 1'b0;
                        mem.data_wr_en_o <= '0;
                        if (mem.mem_ack) begin
                            if (!cmd_q[7]) begin
                                data_q <= mem.data_rd_i;
                            end
                            state <= ST_DONE;
                        end else begin
                            state <= ST_MEM_WAIT;
                        end
                    end
                end

                ST_MEM_WAIT: begin
                    if (mem.mem_ack) begin
                        if (!cmd_q[7]) begin
                            data_q <= mem.data_rd_i;
                        end
                        state <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    resp  <= {cmd_q, addr_q, data_q};
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign miso = resp[FRAME_W-1];

endmodule

// File: tb/tb_spi_mem_slave.sv
// Directed bench for spi_mem_slave: SPI master driver, small TCM memory model, immediate-assert checks.
module tb_spi_mem_slave;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic sclk = 1'b0;
    logic cs   = 1'b1;
    logic mosi = 1'b0;
    logic miso;
    logic start_flag;

    spi_mem_slave_if bus();

    spi_mem_slave #(.FRAME_W(72), .SYNC_STG(2)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .sclk       (sclk),
        .cs         (cs),
        .mosi       (mosi),
        .miso       (miso),
        .start_flag (start_flag),
        .mem        (bus)
    );

    always #5 clk = ~clk;

    logic        stall = 1'b0;
    logic [31:0] mem_arr [0:15];
    int          acc_cnt;
    int          sf_cnt;
    logic [31:0] last_adr;
    logic [31:0] last_wr;
    logic [3:0]  last_en;
    int          errors = 0;
    int          checks = 0;
    logic [71:0] rx;
    int          sf_save;
    int          acc_save;

    always_comb bus.mem_accept = (bus.mem_d_rd_o || (bus.data_wr_en_o != 4'h0)) && !stall;

    // memory model: accepts when not stalled, answers one cycle later
    always @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < 16; i++) mem_arr[i] <= 32'h0;
            mem_arr[4]    <= 32'h1140006F;
            bus.mem_ack   <= 1'b0;
            bus.data_rd_i <= 32'h0;
            acc_cnt       <= 0;
            sf_cnt        <= 0;
            last_adr      <= 32'h0;
            last_wr       <= 32'h0;
            last_en       <= 4'h0;
        end else begin
            bus.mem_ack <= bus.mem_accept;
            if (start_flag) sf_cnt <= sf_cnt + 1;
            if (bus.mem_accept) begin
                acc_cnt       <= acc_cnt + 1;
                last_adr      <= bus.data_adr_o;
                last_wr       <= bus.data_wr_o;
                last_en       <= bus.data_wr_en_o;
                bus.data_rd_i <= mem_arr[bus.data_adr_o[5:2]];
                for (int b = 0; b < 4; b++) begin
                    if (bus.data_wr_en_o[b])
                        mem_arr[bus.data_adr_o[5:2]][8*b +: 8] <= bus.data_wr_o[8*b +: 8];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // LSB-first on mosi, miso sampled just before each rising sclk (MSB first)
    task automatic send_frame(input logic [71:0] tx, input int nbits, output logic [71:0] rx_o);
        rx_o = 72'h0;
        cs = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[i];
            rx_o[71-i] = miso;
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
            repeat (4) @(negedge clk);
        end
        cs = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic wait_req();
        int n = 0;
        while (!(bus.mem_d_rd_o || (bus.data_wr_en_o != 4'h0)) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("req_seen", 72'(n < 50), 72'h1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_miso",  72'(miso), 72'h0);
        chk("rst_rd",    72'(bus.mem_d_rd_o), 72'h0);
        chk("rst_wr_en", 72'(bus.data_wr_en_o), 72'h0);
        chk("rst_start", 72'(start_flag), 72'h0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // read 0x10 with the memory stalled
        stall = 1'b1;
        send_frame(72'h0F_00000010_00000000, 72, rx);
        chk("rx_after_reset", rx, 72'h0);
        wait_req();
        chk("rd_req", 72'(bus.mem_d_rd_o), 72'h1);
        chk("rd_adr", 72'(bus.data_adr_o), 72'h10);
        chk("start_cnt1", 72'(sf_cnt), 72'd1);
        repeat (5) begin
            @(negedge clk);
            chk("stall_rd",  72'(bus.mem_d_rd_o), 72'h1);
            chk("stall_adr", 72'(bus.data_adr_o), 72'h10);
        end
        chk("stall_no_acc", 72'(acc_cnt), 72'd0);
        stall = 1'b0;
        repeat (3) @(negedge clk);
        chk("acc_once", 72'(acc_cnt), 72'd1);
        chk("rd_dropped", 72'(bus.mem_d_rd_o), 72'h0);
        repeat (10) @(negedge clk);

        // full-word write to 0x20
        send_frame(72'h8F_00000020_DEADBEEF, 72, rx);
        chk("rx_read10", rx, 72'h0F_00000010_1140006F);
        repeat (10) @(negedge clk);
        chk("wr_en",  72'(last_en),  72'hF);
        chk("wr_dat", 72'(last_wr),  72'hDEADBEEF);
        chk("wr_adr", 72'(last_adr), 72'h20);
        chk("acc2",   72'(acc_cnt),  72'd2);

        send_frame(72'h0F_00000020_00000000, 72, rx);
        chk("rx_write20", rx, 72'h8F_00000020_DEADBEEF);
        repeat (10) @(negedge clk);

        // byte write lane 0
        send_frame(72'h81_00000020_000000AA, 72, rx);
        chk("rx_read20", rx, 72'h0F_00000020_DEADBEEF);
        repeat (10) @(negedge clk);
        chk("bw_en", 72'(last_en), 72'h1);
        chk("bw_mem", 72'(mem_arr[8]), 72'hDEADBEAA);

        send_frame(72'h0F_00000020_00000000, 72, rx);
        chk("rx_bytewr", rx, 72'h81_00000020_000000AA);
        repeat (10) @(negedge clk);

        send_frame(72'h0F_00000010_00000000, 72, rx);
        chk("rx_readback", rx, 72'h0F_00000020_DEADBEAA);
        repeat (10) @(negedge clk);

        // abort after 40 bits
        sf_save  = sf_cnt;
        acc_save = acc_cnt;
        send_frame(72'h8F_00000000_12345678, 40, rx);
        repeat (20) @(negedge clk);
        chk("abort_start", 72'(sf_cnt), 72'(sf_save));
        chk("abort_acc",   72'(acc_cnt), 72'(acc_save));
        chk("abort_rd",    72'(bus.mem_d_rd_o), 72'h0);
        chk("abort_wr",    72'(bus.data_wr_en_o), 72'h0);

        send_frame(72'h0F_00000010_00000000, 72, rx);
        repeat (10) @(negedge clk);
        send_frame(72'h0F_00000000_00000000, 72, rx);
        chk("rx_after_abort", rx, 72'h0F_00000010_1140006F);
        repeat (10) @(negedge clk);
        chk("acc_total",   72'(acc_cnt), 72'd8);
        chk("start_total", 72'(sf_cnt),  72'd8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
